// File: rtl/ota_pkg.sv
// Shared definitions for the OTA sigma-delta stimulus block: mode encodings,
// FSM states and the default code width.
package ota_pkg;

  localparam int unsigned OTA_WIDTH = 8;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    STATIC,
    SAW,
    TRI_UP,
    TRI_DOWN
  } ota_state_e;

endpackage

// File: rtl/ota_ramp_gen.sv
// Ramp code generator: prescaler, sawtooth/triangle counter and the
// end-of-period wrap pulse.
module ota_ramp_gen
  import ota_pkg::*;
#(
  parameter int unsigned WIDTH    = OTA_WIDTH,
  parameter int unsigned RAMP_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en_i,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] ramp_cnt_o,
  output logic             ramp_wrap_o,
  output logic             turn_o
);

  localparam int unsigned DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    down_d = down_q;
    wrap_d = 1'b0;
    turn_o = 1'b0;
    step   = step_en_i && !clear_i && (div_q == DIV_LAST);
    if (clear_i) begin
      div_d  = '0;
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (step_en_i) begin
      div_d = step ? '0 : div_q + DW'(1);
      if (step) begin
        if (mode_i != MODE_TRI) begin
          cnt_d  = cnt_q + WIDTH'(1);
          wrap_d = &cnt_q;
        end else if (!down_q) begin
          // At the peak the code holds for one extra step while turning.
          if (&cnt_q) begin
            down_d = 1'b1;
            turn_o = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            down_d = 1'b0;
            turn_o = 1'b1;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      cnt_q  <= '0;
      down_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      down_q <= down_d;
      wrap_q <= wrap_d;
    end
  end

  assign ramp_cnt_o  = cnt_q;
  assign ramp_wrap_o = wrap_q;

endmodule

// File: rtl/ota_sd_stim.sv
// First-order sigma-delta DAC driving the OTA inputs: static code via
// valid/ready handshake, or sawtooth/triangle sweeps from ota_ramp_gen.
module ota_sd_stim
  import ota_pkg::*;
#(
  parameter int unsigned WIDTH    = OTA_WIDTH,
  parameter int unsigned RAMP_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic             dac_out,
  output logic [WIDTH-1:0] cur_code,
  output logic             ramp_wrap
);

  ota_state_e       state_q, state_d, target;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             dac_q, dac_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] ramp_cnt;
  logic             in_ramp, same_mode, restart, ramp_run, turn;

  always_comb begin
    target = STATIC;
    if (!enable)                target = IDLE;
    else if (mode == MODE_SAW)  target = SAW;
    else if (mode == MODE_TRI)  target = TRI_UP;
  end

  assign in_ramp = (state_q == SAW) || (state_q == TRI_UP) || (state_q == TRI_DOWN);

  // Both triangle phases belong to the single triangle mode.
  always_comb begin
    case (state_q)
      STATIC:           same_mode = (target == STATIC);
      SAW:              same_mode = (target == SAW);
      TRI_UP, TRI_DOWN: same_mode = (target == TRI_UP);
      default:          same_mode = 1'b0;
    endcase
  end

  assign restart    = (state_q != IDLE) && !same_mode;
  assign ramp_run   = in_ramp && !restart;
  assign code_ready = (state_q == STATIC);
  assign cur_code   = in_ramp ? ramp_cnt : code_q;
  assign sum        = {1'b0, acc_q} + {1'b0, cur_code};

  ota_ramp_gen #(
    .WIDTH    (WIDTH),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk         (clk),
    .rst         (rst),
    .step_en_i   (ramp_run),
    .mode_i      (mode),
    .clear_i     (!ramp_run),
    .ramp_cnt_o  (ramp_cnt),
    .ramp_wrap_o (ramp_wrap),
    .turn_o      (turn)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dac_d   = dac_q;
    code_d  = code_q;
    if (code_valid && code_ready) code_d = code_in;
    if ((state_q == IDLE) || restart) begin
      acc_d   = '0;
      dac_d   = 1'b0;
      state_d = target;
    end else begin
      acc_d = sum[WIDTH-1:0];
      dac_d = sum[WIDTH];
      if (turn) state_d = (state_q == TRI_UP) ? TRI_DOWN : TRI_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      code_q  <= '0;
      dac_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      dac_q   <= dac_d;
    end
  end

  assign dac_out = dac_q;

endmodule

// File: tb/tb_ota_sd_stim.sv
// Bench for ota_sd_stim: two instances (RAMP_DIV 2 and 1) on shared inputs,
// checked each cycle against a time-indexed reference model.
module tb_ota_sd_stim;

  logic       clk = 1'b0;
  logic       rst, enable, code_valid;
  logic [1:0] mode;
  logic [7:0] code_in;

  logic       rdy_a, dac_a, wrp_a, rdy_b, dac_b, wrp_b;
  logic [7:0] cur_a, cur_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ota_sd_stim #(.WIDTH(8), .RAMP_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .code_in(code_in),
    .code_valid(code_valid), .code_ready(rdy_a), .dac_out(dac_a),
    .cur_code(cur_a), .ramp_wrap(wrp_a)
  );

  ota_sd_stim #(.WIDTH(8), .RAMP_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .code_in(code_in),
    .code_valid(code_valid), .code_ready(rdy_b), .dac_out(dac_b),
    .cur_code(cur_b), .ramp_wrap(wrp_b)
  );

  // Model: run 0 idle, 1 static, 2 saw, 3 triangle; t = cycles since entry.
  int rdv[2] = '{2, 1};
  int m_run[2], m_t[2], m_acc[2], m_code[2], m_dac[2], m_wrap[2];

  function automatic int m_cur(int i);
    int p;
    if (m_run[i] == 2) return (m_t[i] / rdv[i]) % 256;
    if (m_run[i] == 3) begin
      p = (m_t[i] / rdv[i]) % 512;
      return (p < 256) ? p : 511 - p;
    end
    return m_code[i];
  endfunction

  task automatic model_edge();
    int tgt, nc, s, per;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_t[i] = 0; m_acc[i] = 0; m_code[i] = 0; m_dac[i] = 0; m_wrap[i] = 0;
      end else begin
        tgt = !enable ? 0 : (mode == 2'd1) ? 2 : (mode == 2'd2) ? 3 : 1;
        nc  = (m_run[i] == 1 && code_valid) ? int'(code_in) : m_code[i];
        if (m_run[i] == 0 || tgt != m_run[i]) begin
          m_acc[i] = 0; m_dac[i] = 0; m_wrap[i] = 0; m_t[i] = 0; m_run[i] = tgt;
        end else begin
          s        = m_acc[i] + m_cur(i);
          m_dac[i] = s / 256;
          m_acc[i] = s % 256;
          m_wrap[i] = 0;
          if (m_run[i] >= 2) begin
            m_t[i]++;
            per = (m_run[i] == 2) ? 256 : 512;
            m_wrap[i] = ((m_t[i] % (per * rdv[i])) == 0) ? 1 : 0;
          end
        end
        m_code[i] = nc;
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("A.dac", int'(dac_a), m_dac[0]);
    chk("A.cur", int'(cur_a), m_cur(0));
    chk("A.ready", int'(rdy_a), (m_run[0] == 1) ? 1 : 0);
    chk("A.wrap", int'(wrp_a), m_wrap[0]);
    chk("B.dac", int'(dac_b), m_dac[1]);
    chk("B.cur", int'(cur_b), m_cur(1));
    chk("B.ready", int'(rdy_b), (m_run[1] == 1) ? 1 : 0);
    chk("B.wrap", int'(wrp_b), m_wrap[1]);
  endtask

  task automatic density(int c);
    int ones_a, ones_b;
    code_valid = 1'b1; code_in = 8'(c);
    tick();
    code_valid = 1'b0;
    ones_a = 0; ones_b = 0;
    repeat (256) begin
      tick();
      ones_a += int'(dac_a);
      ones_b += int'(dac_b);
    end
    chk($sformatf("density_a_%0d", c), ones_a, c);
    chk($sformatf("density_b_%0d", c), ones_b, c);
  endtask

  typedef struct {
    logic       r;
    logic       en;
    logic [1:0] md;
    logic       cv;
    logic [7:0] ci;
    logic       e_rdy;
    logic       e_dac;
    logic [7:0] e_cur;
    logic       e_wrap;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int wraps_a, wraps_b, pos_a, cur255, cur256, cur511, found;
    rst = 1'b1; enable = 1'b1; mode = 2'd0; code_valid = 1'b0; code_in = '0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_t[i] = 0; m_acc[i] = 0; m_code[i] = 0; m_dac[i] = 0; m_wrap[i] = 0;
    end

    // Reset, static load of 128, switch to saw, abort to idle, re-enter static.
    tbl[0]  = '{1, 1, 2'd0, 0, 8'd0,   0, 0, 8'd0,   0};
    tbl[1]  = '{1, 1, 2'd0, 0, 8'd0,   0, 0, 8'd0,   0};
    tbl[2]  = '{1, 1, 2'd0, 0, 8'd0,   0, 0, 8'd0,   0};
    tbl[3]  = '{0, 1, 2'd0, 0, 8'd0,   1, 0, 8'd0,   0};
    tbl[4]  = '{0, 1, 2'd0, 1, 8'd128, 1, 0, 8'd128, 0};
    tbl[5]  = '{0, 1, 2'd0, 0, 8'd0,   1, 0, 8'd128, 0};
    tbl[6]  = '{0, 1, 2'd0, 0, 8'd0,   1, 1, 8'd128, 0};
    tbl[7]  = '{0, 1, 2'd0, 0, 8'd0,   1, 0, 8'd128, 0};
    tbl[8]  = '{0, 1, 2'd0, 0, 8'd0,   1, 1, 8'd128, 0};
    tbl[9]  = '{0, 1, 2'd1, 0, 8'd0,   0, 0, 8'd0,   0};
    tbl[10] = '{0, 1, 2'd1, 0, 8'd0,   0, 0, 8'd0,   0};
    tbl[11] = '{0, 1, 2'd1, 0, 8'd0,   0, 0, 8'd1,   0};
    tbl[12] = '{0, 1, 2'd1, 0, 8'd0,   0, 0, 8'd1,   0};
    tbl[13] = '{0, 1, 2'd1, 0, 8'd0,   0, 0, 8'd2,   0};
    tbl[14] = '{0, 0, 2'd1, 0, 8'd0,   0, 0, 8'd128, 0};
    tbl[15] = '{0, 1, 2'd0, 0, 8'd0,   1, 0, 8'd128, 0};

    for (int v = 0; v < 16; v++) begin
      rst = tbl[v].r; enable = tbl[v].en; mode = tbl[v].md;
      code_valid = tbl[v].cv; code_in = tbl[v].ci;
      tick();
      chk($sformatf("vec%0d.ready", v), int'(rdy_a), int'(tbl[v].e_rdy));
      chk($sformatf("vec%0d.dac", v), int'(dac_a), int'(tbl[v].e_dac));
      chk($sformatf("vec%0d.cur", v), int'(cur_a), int'(tbl[v].e_cur));
      chk($sformatf("vec%0d.wrap", v), int'(wrp_a), int'(tbl[v].e_wrap));
    end
    code_valid = 1'b0;

    // Static density, including both boundary codes.
    density(128);
    density(64);
    density(0);
    density(255);

    // Handshake ignored outside STATIC, accepted on first ready cycle.
    mode = 2'd1; tick();
    code_valid = 1'b1; code_in = 8'd10;
    repeat (3) tick();
    chk("hs_ready_saw", int'(rdy_a), 0);
    code_in = 8'd200;
    repeat (3) tick();
    mode = 2'd0; tick();
    chk("hs_code_kept", int'(cur_a), 255);
    chk("hs_ready_static", int'(rdy_a), 1);
    tick();
    chk("hs_code_loaded", int'(cur_a), 200);
    code_valid = 1'b0;
    begin
      int ones = 0;
      repeat (256) begin tick(); ones += int'(dac_a); end
      chk("hs_density_200", ones, 200);
    end

    // Sawtooth period.
    enable = 1'b0; tick();
    enable = 1'b1; mode = 2'd1; tick();
    wraps_a = 0; wraps_b = 0; pos_a = -1;
    for (int k = 1; k <= 512; k++) begin
      tick();
      if (wrp_a) begin wraps_a++; pos_a = k; end
      if (wrp_b) wraps_b++;
    end
    chk("saw_wraps_a", wraps_a, 1);
    chk("saw_wrap_pos_a", pos_a, 512);
    chk("saw_cur_after_wrap", int'(cur_a), 0);
    chk("saw_wraps_b", wraps_b, 2);

    // Triangle period on the undivided instance.
    enable = 1'b0; tick();
    enable = 1'b1; mode = 2'd2; tick();
    wraps_b = 0; pos_a = -1; cur255 = -1; cur256 = -1; cur511 = -1;
    for (int k = 1; k <= 512; k++) begin
      tick();
      if (wrp_b) begin wraps_b++; pos_a = k; end
      if (k == 255) cur255 = int'(cur_b);
      if (k == 256) cur256 = int'(cur_b);
      if (k == 511) cur511 = int'(cur_b);
    end
    chk("tri_peak_first", cur255, 255);
    chk("tri_peak_hold", cur256, 255);
    chk("tri_trough", cur511, 0);
    chk("tri_trough_hold", int'(cur_b), 0);
    chk("tri_wraps", wraps_b, 1);
    chk("tri_wrap_pos", pos_a, 512);

    // Abort mid-sawtooth at code 77.
    enable = 1'b0; tick();
    enable = 1'b1; mode = 2'd1; tick();
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      tick();
      if (cur_a == 8'd77) found = 1;
    end
    chk("abort_reach_77", found, 1);
    enable = 1'b0; tick();
    chk("abort_dac", int'(dac_a), 0);
    chk("abort_ready", int'(rdy_a), 0);
    chk("abort_code_kept", int'(cur_a), 200);
    enable = 1'b1; tick();
    chk("abort_restart0", int'(cur_a), 0);
    tick(); tick();
    chk("abort_restart1", int'(cur_a), 1);

    // Reset overrides a handshake in the same cycle.
    mode = 2'd0; tick();
    code_valid = 1'b1; code_in = 8'd99; rst = 1'b1; tick();
    chk("rst_hs_code", int'(cur_a), 0);
    chk("rst_hs_ready", int'(rdy_a), 0);
    rst = 1'b0; code_valid = 1'b0; tick();
    chk("rst_hs_static_code", int'(cur_a), 0);
    chk("rst_hs_static_ready", int'(rdy_a), 1);

    // Randomized operation against the model.
    repeat (4000) begin
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      code_valid = 1'($urandom_range(0, 1));
      code_in    = 8'($urandom_range(0, 255));
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ota_sd_stim.md
Name: ota_sd_stim

Overview:
- First-order sigma-delta DAC that drives the OTA input pins (Vip/Vin) through an off-chip RC filter.
- It is the transmit side of the OTA analog path: a digital code becomes a 1-bit pulse-density stream whose filtered average is the analog stimulus.
- Supports a static code loaded by handshake, plus sawtooth and triangle sweeps for on-chip characterisation of the OTA.
- Sits inside the top-level tile; its output is routed to a ua[] pin.

Parameters:
- WIDTH, 8: code and accumulator width in bits. Output density = code / 2^WIDTH.
- RAMP_DIV, 16: clock cycles per ramp step, minimum 1.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  modulator run. Low forces IDLE.
- mode  in  2  00 static, 01 sawtooth, 10 triangle, 11 reserved (behaves as static).
- code_in  in  WIDTH  static code.
- code_valid  in  1  code_in valid.
- code_ready  out  1  block accepts code_in this cycle.
- dac_out  out  1  registered pulse-density bitstream.
- cur_code  out  WIDTH  code currently being modulated.
- ramp_wrap  out  1  one-cycle pulse at the end of each ramp period.

Behaviour:
- Reset (rst high at a clk edge): state IDLE; acc, code_reg, ramp_cnt, div_cnt = 0; dac_out = 0; ramp_wrap = 0; code_ready = 0. Reset mid-stream overrides everything, including a handshake in the same cycle.
- States: IDLE, STATIC, SAW, TRI_UP, TRI_DOWN.
- IDLE: acc and div_cnt held at 0; dac_out = 0; code_reg retained.
  - Exits when enable = 1, going to the state selected by mode. Triangle always enters TRI_UP.
- Mode change or enable fall while running:
  - Next edge goes to the new state (or IDLE).
  - acc, div_cnt and ramp_cnt are cleared.
  - code_reg is retained.
- Modulator, every edge outside IDLE:
  - sum = {1'b0, acc} + {1'b0, cur_code} (WIDTH+1 bits).
  - acc <= sum[WIDTH-1:0]; dac_out <= sum[WIDTH].
  - cur_code = code_reg in STATIC; cur_code = ramp_cnt in ramp states.
- Handshake:
  - code_ready = 1 iff state is STATIC. It is combinational from the state register only, never from code_valid.
  - Transfer when code_valid && code_ready: code_reg <= code_in on that edge.
  - The new code enters the sum on the next edge. acc is not cleared on load.
  - code_valid in any other state is ignored, with no stall or overflow.
- Boundaries:
  - code 0 gives dac_out constantly 0.
  - code 2^WIDTH-1 gives exactly one 0 per 2^WIDTH cycles.
  - No saturation anywhere; acc wraps modulo 2^WIDTH by construction.
- div_cnt (ramp states only):
  - Counts 0..RAMP_DIV-1.
  - The step fires on the edge where div_cnt = RAMP_DIV-1; div_cnt then returns to 0.
- SAW: on each step ramp_cnt increments. From 2^WIDTH-1 it wraps to 0, and ramp_wrap = 1 for that one cycle.
- TRI_UP: on each step ramp_cnt increments. If ramp_cnt = 2^WIDTH-1 at the step, it holds and the state goes to TRI_DOWN instead, so the peak lasts 2 steps.
- TRI_DOWN: on each step ramp_cnt decrements. If ramp_cnt = 0 at the step, it holds, the state goes to TRI_UP, and ramp_wrap = 1 for one cycle.
- ramp_wrap is registered and is 0 outside ramp states.
- Latency: from the load edge k, the first sum using the new code happens at edge k+1, and its carry appears on dac_out after edge k+1.

Decomposition:
- Shared package ota_pkg holds:
  - mode encodings MODE_STATIC, MODE_SAW, MODE_TRI;
  - the state enum (IDLE, STATIC, SAW, TRI_UP, TRI_DOWN);
  - the default WIDTH constant.
- One natural sub-module: ota_ramp_gen. It contains div_cnt, ramp_cnt, direction and ramp_wrap, with inputs step-enable, mode and clear.
- The accumulator and FSM stay in ota_sd_stim.

Test Plan:
- Reset then idle: rst high 3 cycles with enable=1 → dac_out=0, code_ready=0, cur_code=0; first edge after rst low enters STATIC and code_ready=1.
- Static density: mode=00, load 128 → dac_out alternates 0,1 from the cycle after load; over 256 cycles exactly 128 ones. Repeat for code 64 (1 in 4) and code 0 (all zeros).
- Handshake: hold code_valid with codes 10,200 in SAW mode → code_ready=0 and code_reg unchanged; switch to STATIC → 200 accepted on the first ready cycle; 200 ones counted per 256 cycles.
- Sawtooth: RAMP_DIV=2, mode=01 → cur_code steps every 2 cycles 0→255; ramp_wrap pulses once, 512 cycles after entry, as cur_code returns to 0.
- Triangle: RAMP_DIV=1, mode=10 → cur_code 0..255, holds 255 for 2 cycles, 254..0, holds 0; ramp_wrap pulses once per 512-cycle period, in the cycle cur_code holds at 0.
- Mid-operation abort: enable low during SAW at cur_code=77 → next cycle IDLE and dac_out=0; re-enable → ramp restarts at 0. rst during a STATIC handshake → code_reg=0.
